// File: rtl/idli_pkg.sv
// Shared types and defaults for the idli memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   idli_arb_state_t - arbiter sequencing states (word-granular).
//   IDLI_LAT_WORDS   - default SQI read latency in whole words.
//   IDLI_RESET_PC    - default fetch word address after reset.
//   idli_nib_sel     - pick nibble idx (LSB first) out of a 16-bit word.
package idli_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_F_ADDR   = 3'd1,
    ARB_F_WAIT   = 3'd2,
    ARB_F_STREAM = 3'd3,
    ARB_L_ADDR   = 3'd4,
    ARB_L_WAIT   = 3'd5,
    ARB_L_DATA   = 3'd6
  } idli_arb_state_t;

  localparam int unsigned IDLI_LAT_WORDS = 2;
  localparam logic [15:0] IDLI_RESET_PC  = 16'h0000;

  function automatic logic [3:0] idli_nib_sel(input logic [15:0] i_word,
                                              input logic [1:0]  i_idx);
    return i_word[4*i_idx +: 4];
  endfunction

endpackage

// File: rtl/idli_nib_sreg_m.sv
// Nibble-serial 16-bit capture register (LSB nibble first).
// Latency: o_word is combinational; it holds the full word during the 4th nibble.
// Backpressure: none; shifts whenever i_en is high.
//
// Ports:
//   i_gck   - clock.
//   i_rst_n - asynchronous active-low reset, clears the held nibbles.
//   i_en    - shift i_nib in this cycle.
//   i_nib   - incoming nibble.
//   o_word  - {i_nib, three previously held nibbles}; on the last nibble of a
//             word this is the complete captured value, ready to be used at
//             the same clock edge that would shift it in.
module idli_nib_sreg_m (
  input  logic        i_gck,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [3:0]  i_nib,
  output logic [15:0] o_word
);

  // Only three nibbles need storing: the fourth is the live input when the
  // word completes, so the full 16-bit value is available without a cycle
  // of delay at the word boundary.
  logic [11:0] r_hold;

  assign o_word = {i_nib, r_hold};

  always_ff @(posedge i_gck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold <= '0;
    end else if (i_en) begin
      r_hold <= {i_nib, r_hold[11:4]};
    end
  end

endmodule

// File: rtl/idli_mem_arb_m.sv
// Arbitrates the single SQI port between instruction fetch and load/store.
// Latency: address word, LAT_WORDS wait words, then data; outputs are
// combinational from state and nibble index.
// Backpressure: LSU request held until o_arb_lsu_done; branches held one word.
//
// Ports:
//   i_arb_gck / i_arb_rst_n      - clock, async active-low reset.
//   i_arb_ctr / _ctr_last_cycle  - nibble index in word, word boundary flag.
//   i_arb_br_vld / _br_addr      - branch redirect, target nibble-serial.
//   i_arb_lsu_req/_wr/_addr/_wdata - load/store request, nibble-serial.
//   o_arb_fetch_vld / _lsu_vld   - SQI read nibble is instruction / load data.
//   o_arb_lsu_done               - pulse on the last cycle of the LSU data word.
//   o_arb_sqi_*                  - redirect, read select, write nibble + valid.
module idli_mem_arb_m
  import idli_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = IDLI_RESET_PC,
  parameter int unsigned LAT_WORDS = IDLI_LAT_WORDS
) (
  input  logic       i_arb_gck,
  input  logic       i_arb_rst_n,
  input  logic [1:0] i_arb_ctr,
  input  logic       i_arb_ctr_last_cycle,
  input  logic       i_arb_br_vld,
  input  logic [3:0] i_arb_br_addr,
  input  logic       i_arb_lsu_req,
  input  logic       i_arb_lsu_wr,
  input  logic [3:0] i_arb_lsu_addr,
  input  logic [3:0] i_arb_lsu_wdata,
  output logic       o_arb_fetch_vld,
  output logic       o_arb_lsu_vld,
  output logic       o_arb_lsu_done,
  output logic       o_arb_sqi_redirect,
  output logic       o_arb_sqi_rd,
  output logic [3:0] o_arb_sqi_wr_data,
  output logic       o_arb_sqi_wr_data_vld
);

  localparam logic [1:0] WAIT_INIT = 2'(LAT_WORDS - 1);

  idli_arb_state_t r_state;
  idli_arb_state_t w_state_nxt;
  logic [15:0]     r_pc;
  logic [1:0]      r_wait;
  logic [1:0]      w_wait_nxt;
  logic            r_br_pend;
  logic            r_lsu_wr;
  logic [15:0]     w_br_word;
  logic            w_br_now;

  idli_nib_sreg_m u_br_sreg (
    .i_gck   (i_arb_gck),
    .i_rst_n (i_arb_rst_n),
    .i_en    (i_arb_br_vld),
    .i_nib   (i_arb_br_addr),
    .o_word  (w_br_word)
  );

  // A branch is either arriving in this word or was captured earlier while
  // the port was busy with an address phase or an LSU sequence.
  assign w_br_now = r_br_pend | i_arb_br_vld;

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    case (r_state)
      ARB_IDLE: begin
        w_state_nxt = ARB_F_ADDR;
      end
      ARB_F_ADDR: begin
        w_state_nxt = ARB_F_WAIT;
        w_wait_nxt  = WAIT_INIT;
      end
      ARB_F_WAIT: begin
        if (w_br_now) begin
          w_state_nxt = ARB_F_ADDR;
        end else if (r_wait == 2'd0) begin
          w_state_nxt = ARB_F_STREAM;
        end else begin
          w_wait_nxt = r_wait - 2'd1;
        end
      end
      ARB_F_STREAM: begin
        // LSU only gets in from here, so every fetch redirect delivers at
        // least one instruction word before the port is given away.
        if (i_arb_lsu_req) begin
          w_state_nxt = ARB_L_ADDR;
        end else if (w_br_now) begin
          w_state_nxt = ARB_F_ADDR;
        end
      end
      ARB_L_ADDR: begin
        w_state_nxt = r_lsu_wr ? ARB_L_DATA : ARB_L_WAIT;
        w_wait_nxt  = WAIT_INIT;
      end
      ARB_L_WAIT: begin
        if (r_wait == 2'd0) begin
          w_state_nxt = ARB_L_DATA;
        end else begin
          w_wait_nxt = r_wait - 2'd1;
        end
      end
      ARB_L_DATA: begin
        w_state_nxt = ARB_F_ADDR;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_arb_gck or negedge i_arb_rst_n) begin
    if (!i_arb_rst_n) begin
      r_state   <= ARB_IDLE;
      r_pc      <= RESET_PC;
      r_wait    <= '0;
      r_br_pend <= 1'b0;
      r_lsu_wr  <= 1'b0;
    end else if (i_arb_ctr_last_cycle) begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;

      // A branch target overrides the sequential increment of the fetch
      // word it arrived in; 16-bit add wraps FFFF -> 0000 naturally.
      if (i_arb_br_vld) begin
        r_pc <= w_br_word;
      end else if (r_state == ARB_F_STREAM) begin
        r_pc <= r_pc + 16'd1;
      end

      if (w_state_nxt == ARB_F_ADDR) begin
        r_br_pend <= 1'b0;
      end else if (i_arb_br_vld) begin
        r_br_pend <= 1'b1;
      end

      // Direction is latched as the LSU sequence starts so the address and
      // data words stay consistent for the whole transaction.
      if (r_state == ARB_F_STREAM) begin
        r_lsu_wr <= i_arb_lsu_wr;
      end
    end
  end

  always_comb begin
    o_arb_fetch_vld       = 1'b0;
    o_arb_lsu_vld         = 1'b0;
    o_arb_lsu_done        = 1'b0;
    o_arb_sqi_redirect    = 1'b0;
    o_arb_sqi_rd          = 1'b1;
    o_arb_sqi_wr_data     = 4'h0;
    o_arb_sqi_wr_data_vld = 1'b0;
    case (r_state)
      ARB_F_ADDR: begin
        o_arb_sqi_redirect    = 1'b1;
        o_arb_sqi_wr_data     = idli_nib_sel(r_pc, i_arb_ctr);
        o_arb_sqi_wr_data_vld = 1'b1;
      end
      ARB_F_STREAM: begin
        o_arb_fetch_vld = 1'b1;
      end
      ARB_L_ADDR: begin
        o_arb_sqi_redirect    = 1'b1;
        o_arb_sqi_rd          = ~r_lsu_wr;
        o_arb_sqi_wr_data     = i_arb_lsu_addr;
        o_arb_sqi_wr_data_vld = 1'b1;
      end
      ARB_L_DATA: begin
        if (r_lsu_wr) begin
          o_arb_sqi_rd          = 1'b0;
          o_arb_sqi_wr_data     = i_arb_lsu_wdata;
          o_arb_sqi_wr_data_vld = 1'b1;
        end else begin
          o_arb_lsu_vld = 1'b1;
        end
        o_arb_lsu_done = (i_arb_ctr == 2'd3);
      end
      default: begin
      end
    endcase
  end

endmodule
